// File: rtl/cordic_pkg.sv
// ============================================================================
// Package  : cordic_pkg
// Brief    : Shared widths and FSM state encoding for the CORDIC MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cordic_acc_add.sv
// ============================================================================
// Module   : cordic_acc_add
// Brief    : Sign-extends a product and adds it to the accumulator; saturating
//            when CORDIC_MAC_SAT_EN is defined, modular wrap otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_acc_add
  import cordic_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum
);

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_raw;

  assign w_ext = ACC_W'($signed(i_prod));
  assign w_raw = i_acc + w_ext;

`ifdef CORDIC_MAC_SAT_EN
  localparam logic [ACC_W-1:0] c_pos_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_neg_min = {1'b1, {(ACC_W-1){1'b0}}};

  logic w_ovf;

  // Overflow only possible when both operands share a sign the result lacks.
  assign w_ovf = (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != i_acc[ACC_W-1]);
  assign o_sum = w_ovf ? (i_acc[ACC_W-1] ? c_neg_min : c_pos_max) : w_raw;
`else
  assign o_sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/cordic_mac_sequencer.sv
// ============================================================================
// Module   : cordic_mac_sequencer
// Brief    : Dot-product sequencer around the sequential CORDIC multiplier.
//            Optional macro CORDIC_MAC_SAT_EN selects a saturating accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_mac_sequencer
  import cordic_pkg::*;
#(
  parameter int ACC_W        = 24,
  parameter int MAX_TERMS    = 64,
  parameter int MULT_TIMEOUT = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_x,
  input  logic [OPND_W-1:0] in_z,
  input  logic              in_last,
  output logic              mult_start,
  output logic [OPND_W-1:0] mult_x,
  output logic [OPND_W-1:0] mult_z,
  input  logic [PROD_W-1:0] mult_y,
  input  logic              mult_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  localparam int TMR_W = $clog2(MULT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] c_tmr_last  = TMR_W'(MULT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_max_terms = CNT_W'(MAX_TERMS);

  state_t r_state;
  state_t w_next_state;

  logic [OPND_W-1:0] r_x;
  logic [OPND_W-1:0] r_z;
  logic              r_last;
  logic [TMR_W-1:0]  r_timer;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic [ACC_W-1:0]  w_sum;

  logic w_accept;
  logic w_accum;
  logic w_timeout;
  logic w_release;
  logic w_in_ready;
  logic w_mult_start;
  logic w_out_valid;

  cordic_acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .i_acc  (r_acc),
    .i_prod (mult_y),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_mult_start = 1'b0;
    w_out_valid  = 1'b0;
    w_accept     = 1'b0;
    w_accum      = 1'b0;
    w_timeout    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_mult_start = 1'b1;
        // A done seen on the final timer cycle still wins over the abort.
        if (mult_done) begin
          w_accum      = 1'b1;
          w_next_state = DRAIN;
        end else if (r_timer == c_tmr_last) begin
          w_timeout    = 1'b1;
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (r_last || (r_count == c_max_terms) || r_err) begin
          w_next_state = OUT;
        end else begin
          w_next_state = IDLE;
        end
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_release    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_z     <= '0;
      r_last  <= 1'b0;
      r_timer <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x    <= in_x;
        r_z    <= in_z;
        r_last <= in_last;
      end
      r_timer <= (r_state == RUN) ? r_timer + 1'b1 : '0;
      if (w_accum) begin
        r_acc   <= w_sum;
        r_count <= r_count + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_release) begin
        r_acc   <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign mult_start = w_mult_start;
  assign mult_x     = r_x;
  assign mult_z     = r_z;
  assign out_valid  = w_out_valid;
  assign out_acc    = r_acc;
  assign out_count  = r_count;
  assign out_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cordic_mac_sequencer.sv
// ============================================================================
// Module   : tb_cordic_mac_sequencer
// Brief    : Directed bench for cordic_mac_sequencer with a behavioural
//            multiplier stub (y = x*z, done after a programmable latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [7:0] in_x = '0;
  logic signed [7:0] in_z = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic in_ready, mult_start, mult_done, out_valid, out_err;
  logic signed [7:0] mult_x, mult_z;
  logic signed [15:0] mult_y;
  logic signed [23:0] out_acc;
  logic [6:0] out_count;

  logic in_ready16, mult_start16, mult_done16, out_valid16, out_err16;
  logic signed [7:0] mult_x16, mult_z16;
  logic signed [15:0] mult_y16;
  logic signed [15:0] out_acc16;
  logic [6:0] out_count16;

  int stub_lat = 16;
  logic stub_hang = 1'b0;
  int iter_a = 0;
  int iter_b = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_z(in_z), .in_last(in_last),
    .mult_start(mult_start), .mult_x(mult_x), .mult_z(mult_z),
    .mult_y(mult_y), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_err(out_err)
  );

  cordic_mac_sequencer #(.ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_x(in_x), .in_z(in_z), .in_last(in_last),
    .mult_start(mult_start16), .mult_x(mult_x16), .mult_z(mult_z16),
    .mult_y(mult_y16), .mult_done(mult_done16),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_count(out_count16), .out_err(out_err16)
  );

  // Multiplier stubs: iteration count clears whenever start drops.
  always @(posedge clk) begin
    iter_a <= mult_start ? iter_a + 1 : 0;
    iter_b <= mult_start16 ? iter_b + 1 : 0;
  end
  assign mult_done   = mult_start && !stub_hang && (iter_a >= stub_lat);
  assign mult_y      = 16'(mult_x * mult_z);
  assign mult_done16 = mult_start16 && !stub_hang && (iter_b >= stub_lat);
  assign mult_y16    = 16'(mult_x16 * mult_z16);

  typedef struct {
    logic signed [7:0]  x;
    logic signed [7:0]  z;
    logic               last;
    logic signed [23:0] acc;
    logic signed [15:0] acc16;
    logic [6:0]         cnt;
  } vec_t;

`ifdef CORDIC_MAC_SAT_EN
  localparam logic signed [15:0] c_sat16 = 16'sh8000;
`else
  localparam logic signed [15:0] c_sat16 = 16'sd16768;
`endif

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic signed [7:0] x, input logic signed [7:0] z,
                      input logic last);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_wait: in_ready stuck low for %0d cycles", n);
    end
    in_valid = 1'b1;
    in_x = x;
    in_z = z;
    in_last = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!(in_ready || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL settle: no idle/result after %0d cycles", n);
    end
  endtask

  task automatic measure(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_valid_clear", out_valid, 0);
  endtask

  vec_t vecs[10];
  int lat;

  initial begin
    vecs[0] = '{x:  64, z:   64, last: 1'b1, acc:   4096, acc16:   4096, cnt: 1};
    vecs[1] = '{x:  10, z:   20, last: 1'b0, acc:      0, acc16:      0, cnt: 0};
    vecs[2] = '{x:  -5, z:  100, last: 1'b0, acc:      0, acc16:      0, cnt: 0};
    vecs[3] = '{x: 127, z: -128, last: 1'b1, acc: -16556, acc16: -16556, cnt: 3};
    vecs[4] = '{x: 127, z: -128, last: 1'b0, acc:      0, acc16:      0, cnt: 0};
    vecs[5] = '{x: 127, z: -128, last: 1'b0, acc:      0, acc16:      0, cnt: 0};
    vecs[6] = '{x: 127, z: -128, last: 1'b1, acc: -48768, acc16: c_sat16, cnt: 3};
    vecs[7] = '{x:-128, z: -128, last: 1'b1, acc:  16384, acc16:  16384, cnt: 1};
    vecs[8] = '{x:  -1, z:    1, last: 1'b0, acc:      0, acc16:      0, cnt: 0};
    vecs[9] = '{x:   0, z:   77, last: 1'b1, acc:     -1, acc16:     -1, cnt: 2};

    repeat (3) @(negedge clk);
    check("rst_start", mult_start, 0);
    check("rst_x", mult_x, 0);
    check("rst_valid", out_valid, 0);
    check("rst_acc", out_acc, 0);
    check("rst_count", out_count, 0);
    check("rst_err", out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", in_ready, 1);

    // Nominal latency of a single-term vector
    send(64, 64, 1'b1);
    measure(lat);
    check("lat_nominal", lat, 19);
    check("lat_acc", out_acc, 4096);
    check("lat_count", out_count, 1);
    check("lat_err", out_err, 0);
    handshake();

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].x, vecs[i].z, vecs[i].last);
      settle();
      if (vecs[i].last) begin
        check($sformatf("v%0d_valid", i), out_valid, 1);
        check($sformatf("v%0d_acc", i), out_acc, vecs[i].acc);
        check($sformatf("v%0d_acc16", i), out_acc16, vecs[i].acc16);
        check($sformatf("v%0d_count", i), out_count, vecs[i].cnt);
        check($sformatf("v%0d_err", i), out_err, 0);
        handshake();
      end else begin
        check($sformatf("v%0d_novalid", i), out_valid, 0);
      end
    end

    // Done already high on the first RUN cycle
    stub_lat = 0;
    send(-3, 7, 1'b1);
    measure(lat);
    check("lat_instant", lat, 3);
    check("instant_acc", out_acc, -21);
    handshake();
    stub_lat = 16;

    // Forced end of vector at MAX_TERMS, then a fresh vector
    for (int i = 0; i < 64; i++) begin
      send(1, 1, 1'b0);
      settle();
      if (i < 63) check("max_novalid", out_valid, 0);
    end
    check("max_valid", out_valid, 1);
    check("max_acc", out_acc, 64);
    check("max_count", out_count, 64);
    handshake();
    send(1, 1, 1'b1);
    settle();
    check("after_max_acc", out_acc, 1);
    check("after_max_count", out_count, 1);
    handshake();

    // Multiplier never finishes
    stub_hang = 1'b1;
    send(5, 5, 1'b1);
    measure(lat);
    check("lat_timeout", lat, 26);
    check("to_err", out_err, 1);
    check("to_count", out_count, 0);
    check("to_acc", out_acc, 0);
    handshake();
    check("to_err_clear", out_err, 0);
    stub_hang = 1'b0;
    send(2, 3, 1'b0);
    settle();
    stub_hang = 1'b1;
    send(1, 1, 1'b0);
    settle();
    check("to2_valid", out_valid, 1);
    check("to2_acc", out_acc, 6);
    check("to2_count", out_count, 1);
    check("to2_err", out_err, 1);
    handshake();
    stub_hang = 1'b0;

    // Result held under backpressure while a new operand is offered
    send(9, 9, 1'b1);
    settle();
    in_valid = 1'b1;
    in_x = 1;
    in_z = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_acc", out_acc, 81);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_acc_clear", out_acc, 0);
    check("bp_idle", in_ready, 1);

    // Asynchronous reset in the middle of a product
    send(3, 4, 1'b0);
    settle();
    send(5, 5, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_start", mult_start, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_start", mult_start, 0);
    check("mrst_x", mult_x, 0);
    check("mrst_z", mult_z, 0);
    check("mrst_acc", out_acc, 0);
    check("mrst_count", out_count, 0);
    check("mrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle", in_ready, 1);
    send(2, 2, 1'b1);
    settle();
    check("mrst_new_acc", out_acc, 4);
    check("mrst_new_count", out_count, 1);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
